// File: rtl/seg_scan_decoder.sv
// Rebuilds the hex value shown on a multiplexed 8-digit seven-segment display.
// It watches the active-low segment and anode lines and decodes each digit once its pattern has settled.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  segments,
    input  logic [7:0]  anodes,
    output logic [31:0] hex_out,
    output logic [7:0]  digit_valid,
    output logic        frame_valid,
    output logic        seg_error,
    output logic        anode_error
);

    localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

    logic [14:0] sample_reg;
    logic [7:0]  stable_count;
    logic        captured;
    logic [7:0]  seen_mask;

    logic [14:0] sample_now;
    logic        sample_changed;
    logic        capture;
    logic [7:0]  active;
    logic        no_digit;
    logic        multi_digit;
    logic [2:0]  digit_idx;
    logic        glyph_ok;
    logic [3:0]  glyph_nibble;

    logic [31:0] hex_next;
    logic [7:0]  valid_next;
    logic [7:0]  seen_next;
    logic        seg_error_next;
    logic        anode_error_next;

    assign sample_now     = {anodes, segments};
    assign sample_changed = (sample_now != sample_reg);
    // The captured flag allows only one capture per stable run, even after the counter saturates.
    assign capture        = !captured && (stable_count == STABLE_LIMIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sample_reg   <= '1;
            stable_count <= 8'd0;
            captured     <= 1'b0;
        end else if (sample_changed) begin
            sample_reg   <= sample_now;
            stable_count <= 8'd1;
            captured     <= 1'b0;
        end else begin
            if (stable_count != 8'hFF)
                stable_count <= stable_count + 8'd1;
            if (capture)
                captured <= 1'b1;
        end
    end

    assign active      = ~sample_reg[14:7];
    assign no_digit    = (active == 8'd0);
    assign multi_digit = ((active & (active - 8'd1)) != 8'd0);

    always_comb begin
        digit_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (active[i])
                digit_idx = 3'(i);
        end
    end

    always_comb begin
        glyph_ok     = 1'b1;
        glyph_nibble = 4'h0;
        case (sample_reg[6:0])
            7'h40: glyph_nibble = 4'h0;
            7'h79: glyph_nibble = 4'h1;
            7'h24: glyph_nibble = 4'h2;
            7'h30: glyph_nibble = 4'h3;
            7'h19: glyph_nibble = 4'h4;
            7'h12: glyph_nibble = 4'h5;
            7'h02: glyph_nibble = 4'h6;
            7'h78: glyph_nibble = 4'h7;
            7'h00: glyph_nibble = 4'h8;
            7'h10: glyph_nibble = 4'h9;
            7'h08: glyph_nibble = 4'hA;
            7'h03: glyph_nibble = 4'hB;
            7'h46: glyph_nibble = 4'hC;
            7'h21: glyph_nibble = 4'hD;
            7'h06: glyph_nibble = 4'hE;
            7'h0E: glyph_nibble = 4'hF;
            default: glyph_ok = 1'b0;
        endcase
    end

    // A full seen-mask is cleared in the same cycle that frame_valid fires; a capture in that cycle starts the next frame.
    always_comb begin
        hex_next         = hex_out;
        valid_next       = digit_valid;
        seen_next        = (seen_mask == 8'hFF) ? 8'd0 : seen_mask;
        seg_error_next   = 1'b0;
        anode_error_next = 1'b0;
        if (capture && !no_digit) begin
            if (multi_digit) begin
                anode_error_next = 1'b1;
            end else if (glyph_ok) begin
                hex_next[{digit_idx, 2'b00} +: 4] = glyph_nibble;
                valid_next[digit_idx]             = 1'b1;
                seen_next[digit_idx]              = 1'b1;
            end else begin
                valid_next[digit_idx] = 1'b0;
                seg_error_next        = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hex_out     <= 32'd0;
            digit_valid <= 8'd0;
            seen_mask   <= 8'd0;
            frame_valid <= 1'b0;
            seg_error   <= 1'b0;
            anode_error <= 1'b0;
        end else begin
            hex_out     <= hex_next;
            digit_valid <= valid_next;
            seen_mask   <= seen_next;
            frame_valid <= (seen_mask == 8'hFF);
            seg_error   <= seg_error_next;
            anode_error <= anode_error_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus randomized scanning,
// compared against a run-length reference model of the display capture rules.
module tb_seg_scan_decoder;

    localparam int S = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  segments = 7'h7F;
    logic [7:0]  anodes = 8'hFF;
    logic [31:0] hex_out;
    logic [7:0]  digit_valid;
    logic        frame_valid;
    logic        seg_error;
    logic        anode_error;

    int n_compared = 0;
    int n_mismatched = 0;

    logic [6:0] glyph_table [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [31:0] m_hex;
    logic [7:0]  m_dv, m_seen;
    logic        m_fv, m_se, m_ae;
    logic        pend;
    logic [14:0] pend_val, last;
    int          run;

    seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clock(clock), .reset(reset), .segments(segments), .anodes(anodes),
        .hex_out(hex_out), .digit_valid(digit_valid), .frame_valid(frame_valid),
        .seg_error(seg_error), .anode_error(anode_error)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        m_hex = 32'd0; m_dv = 8'd0; m_seen = 8'd0;
        m_fv = 1'b0; m_se = 1'b0; m_ae = 1'b0;
        pend = 1'b0; pend_val = '1; last = '1; run = 0;
    endtask

    // A pattern seen for exactly S consecutive samples is decoded and shows up one edge later.
    task automatic model_edge(input logic [7:0] an, input logic [6:0] seg);
        logic [7:0] act;
        int found, idx;
        m_fv = (m_seen == 8'hFF);
        if (m_fv) m_seen = 8'd0;
        m_se = 1'b0;
        m_ae = 1'b0;
        if (pend) begin
            act = ~pend_val[14:7];
            if ($countones(act) > 1) begin
                m_ae = 1'b1;
            end else if ($countones(act) == 1) begin
                idx = 0;
                for (int i = 0; i < 8; i++) if (act[i]) idx = i;
                found = -1;
                for (int g = 0; g < 16; g++) if (glyph_table[g] == pend_val[6:0]) found = g;
                if (found >= 0) begin
                    m_hex[idx*4 +: 4] = 4'(found);
                    m_dv[idx] = 1'b1;
                    m_seen[idx] = 1'b1;
                end else begin
                    m_dv[idx] = 1'b0;
                    m_se = 1'b1;
                end
            end
        end
        if ({an, seg} == last) run++;
        else begin
            last = {an, seg};
            run = 1;
        end
        pend = (run == S);
        pend_val = {an, seg};
    endtask

    task automatic applyStimulus(input logic [7:0] an, input logic [6:0] seg);
        anodes = an;
        segments = seg;
        @(posedge clock);
        #1;
        if (!reset) model_reset();
        else model_edge(an, seg);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        anodes = 8'hFF;
        segments = 7'h7F;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        applyStimulus(8'hFF, 7'h7F);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        n_compared++;
        if ({hex_out, digit_valid, frame_valid, seg_error, anode_error} !== 43'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_values: got hex=%h dv=%h fv=%b se=%b ae=%b, want all zero",
                     hex_out, digit_valid, frame_valid, seg_error, anode_error);
        end
        reset = 1'b1;
        repeat (6) applyStimulus(8'hFF, 7'h7F);
    endtask

    task automatic test_single_capture();
        int changes = 0;
        logic [39:0] prev;
        prev = {hex_out, digit_valid};
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(8'hFE, 7'h30);
            n_compared++;
            if ({hex_out, digit_valid, frame_valid, seg_error, anode_error} !== {m_hex, m_dv, m_fv, m_se, m_ae}) begin
                n_mismatched++;
                $display("[TB] FAIL single_cycle%0d: got %h/%h/%b%b%b want %h/%h/%b%b%b", c,
                         hex_out, digit_valid, frame_valid, seg_error, anode_error, m_hex, m_dv, m_fv, m_se, m_ae);
            end
            if ({hex_out, digit_valid} !== prev) changes++;
            prev = {hex_out, digit_valid};
            if (c == 4) begin
                n_compared++;
                if (digit_valid !== 8'h00) begin
                    n_mismatched++;
                    $display("[TB] FAIL single_early: got dv=%h want 00 at edge 4", digit_valid);
                end
            end
            if (c == 5) begin
                n_compared++;
                if (digit_valid !== 8'h01 || hex_out[3:0] !== 4'h3) begin
                    n_mismatched++;
                    $display("[TB] FAIL single_latency: got dv=%h nib0=%h want 01/3 at edge 5", digit_valid, hex_out[3:0]);
                end
            end
        end
        n_compared++;
        if (changes != 1) begin
            n_mismatched++;
            $display("[TB] FAIL single_once: got %0d output updates want 1", changes);
        end
    endtask

    task automatic test_frame();
        int fv_count = 0;
        int fv_cycle = -1;
        do_reset();
        for (int d = 0; d < 8; d++) begin
            for (int k = 0; k < 6; k++) begin
                applyStimulus(~(8'd1 << d), glyph_table[d + 1]);
                n_compared++;
                if ({hex_out, digit_valid, frame_valid, seg_error, anode_error} !== {m_hex, m_dv, m_fv, m_se, m_ae}) begin
                    n_mismatched++;
                    $display("[TB] FAIL frame_d%0d_k%0d: got %h/%h/%b%b%b want %h/%h/%b%b%b", d, k,
                             hex_out, digit_valid, frame_valid, seg_error, anode_error, m_hex, m_dv, m_fv, m_se, m_ae);
                end
                if (frame_valid) begin
                    fv_count++;
                    fv_cycle = d * 6 + k + 1;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(8'hFF, 7'h7F);
            if (frame_valid) fv_count++;
        end
        n_compared++;
        if (hex_out !== 32'h87654321 || digit_valid !== 8'hFF) begin
            n_mismatched++;
            $display("[TB] FAIL frame_value: got %h/%h want 87654321/ff", hex_out, digit_valid);
        end
        n_compared++;
        if (fv_count != 1 || fv_cycle != 48) begin
            n_mismatched++;
            $display("[TB] FAIL frame_pulse: got %0d pulses at cycle %0d want 1 at cycle 48", fv_count, fv_cycle);
        end
    endtask

    task automatic test_seg_error();
        int se_count = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(8'hFB, 7'h7F);
            n_compared++;
            if ({hex_out, digit_valid, frame_valid, seg_error, anode_error} !== {m_hex, m_dv, m_fv, m_se, m_ae}) begin
                n_mismatched++;
                $display("[TB] FAIL segerr_k%0d: got %h/%h/%b%b%b want %h/%h/%b%b%b", k,
                         hex_out, digit_valid, frame_valid, seg_error, anode_error, m_hex, m_dv, m_fv, m_se, m_ae);
            end
            if (seg_error) se_count++;
        end
        n_compared++;
        if (se_count != 1 || digit_valid !== 8'hFB || hex_out[11:8] !== 4'h3) begin
            n_mismatched++;
            $display("[TB] FAIL segerr_result: got pulses=%0d dv=%h nib2=%h want 1/fb/3", se_count, digit_valid, hex_out[11:8]);
        end
    endtask

    task automatic test_anode_error();
        int ae_count = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(8'hFC, 7'h24);
            n_compared++;
            if ({hex_out, digit_valid, frame_valid, seg_error, anode_error} !== {m_hex, m_dv, m_fv, m_se, m_ae}) begin
                n_mismatched++;
                $display("[TB] FAIL anerr_k%0d: got %h/%h/%b%b%b want %h/%h/%b%b%b", k,
                         hex_out, digit_valid, frame_valid, seg_error, anode_error, m_hex, m_dv, m_fv, m_se, m_ae);
            end
            if (anode_error) ae_count++;
        end
        n_compared++;
        if (ae_count != 1 || hex_out !== 32'h87654321 || digit_valid !== 8'hFB) begin
            n_mismatched++;
            $display("[TB] FAIL anerr_result: got pulses=%0d hex=%h dv=%h want 1/87654321/fb", ae_count, hex_out, digit_valid);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(8'hFE, ((c / 2) % 2 == 0) ? 7'h40 : 7'h79);
            if (frame_valid || seg_error || anode_error) pulses++;
        end
        n_compared++;
        if (pulses != 0 || hex_out !== 32'h87654321 || digit_valid !== 8'hFB) begin
            n_mismatched++;
            $display("[TB] FAIL glitch_hold: got pulses=%0d hex=%h dv=%h want 0/87654321/fb", pulses, hex_out, digit_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        int fv_count = 0;
        for (int d = 0; d < 5; d++)
            for (int k = 0; k < 6; k++) applyStimulus(~(8'd1 << d), glyph_table[d]);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        n_compared++;
        if ({hex_out, digit_valid, frame_valid, seg_error, anode_error} !== 43'd0) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset: got hex=%h dv=%h fv=%b se=%b ae=%b want all zero",
                     hex_out, digit_valid, frame_valid, seg_error, anode_error);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(8'hFE, 7'h30);
            n_compared++;
            if ({hex_out, digit_valid, frame_valid, seg_error, anode_error} !== 43'd0) begin
                n_mismatched++;
                $display("[TB] FAIL held_reset_k%0d: got %h/%h/%b%b%b want zero", k,
                         hex_out, digit_valid, frame_valid, seg_error, anode_error);
            end
        end
        reset = 1'b1;
        for (int d = 0; d < 8; d++) begin
            for (int k = 0; k < 6; k++) begin
                applyStimulus(~(8'd1 << d), glyph_table[(d + 9) % 16]);
                if (frame_valid) fv_count++;
            end
        end
        applyStimulus(8'hFF, 7'h7F);
        if (frame_valid) fv_count++;
        n_compared++;
        if (fv_count != 1 || hex_out !== 32'h0FEDCBA9 || digit_valid !== 8'hFF) begin
            n_mismatched++;
            $display("[TB] FAIL rescan: got pulses=%0d hex=%h dv=%h want 1/0fedcba9/ff", fv_count, hex_out, digit_valid);
        end
    endtask

    task automatic test_random();
        logic [7:0] an;
        logic [6:0] seg;
        int hold, kind;
        for (int r = 0; r < 120; r++) begin
            kind = int'($urandom_range(0, 7));
            if (kind == 0) an = 8'hFF;
            else if (kind == 1) an = ~((8'd1 << $urandom_range(0, 3)) | (8'd1 << $urandom_range(4, 7)));
            else an = ~(8'd1 << $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) seg = 7'($urandom);
            else seg = glyph_table[$urandom_range(0, 15)];
            hold = int'($urandom_range(1, 7));
            for (int k = 0; k < hold; k++) begin
                applyStimulus(an, seg);
                n_compared++;
                if ({hex_out, digit_valid, frame_valid, seg_error, anode_error} !== {m_hex, m_dv, m_fv, m_se, m_ae}) begin
                    n_mismatched++;
                    $display("[TB] FAIL random_r%0d_k%0d: got %h/%h/%b%b%b want %h/%h/%b%b%b", r, k,
                             hex_out, digit_valid, frame_valid, seg_error, anode_error, m_hex, m_dv, m_fv, m_se, m_ae);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_capture();
        test_frame();
        test_seg_error();
        test_anode_error();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, gives the consecutive identical samples required before a digit is captured; legal range is 1..255.
REQ-002 clock  in  1  single system clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 segments  in  7  active-low segment lines, bit0=a ... bit6=g, as driven by the team's display multiplexer.
REQ-005 anodes  in  8  active-low digit enables; bit i selects digit i.
REQ-006 hex_out  out  32  reconstructed display value; nibble i is hex_out[4i+3:4i].
REQ-007 digit_valid  out  8  bit i SHALL be 1 when nibble i holds a successfully decoded glyph.
REQ-008 frame_valid  out  1  one-cycle pulse when all 8 digits have been captured since the previous pulse or reset.
REQ-009 seg_error  out  1  one-cycle pulse on capture of an undecodable segment pattern.
REQ-010 anode_error  out  1  one-cycle pulse when a stable anode pattern has more than one low bit.

Function
REQ-011 The block SHALL register {anodes, segments} every cycle and run a saturating 8-bit counter of consecutive identical samples; any change SHALL reset the count to 1.
REQ-012 Capture SHALL occur on the edge where the count reaches STABLE_CYCLES; only one capture per stable run, with no recapture while the input holds.
REQ-013 For a capture with exactly one anode bit i low, segments SHALL be decoded (active-low, hex) as: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-014 On a decodable capture: nibble i SHALL be loaded, digit_valid[i] set, and seen-mask bit i set.
REQ-015 On an undecodable capture for digit i: nibble i SHALL be held, digit_valid[i] cleared, seg_error pulsed, and the seen-mask left unchanged.
REQ-016 anodes all high (blank) SHALL cause no capture and no error.
REQ-017 Two or more anode bits low at capture SHALL pulse anode_error and change no other state.
REQ-018 When the seen-mask becomes 8'hFF, frame_valid SHALL pulse on the following cycle and the seen-mask SHALL clear in that same cycle; digit_valid and hex_out SHALL be held.
REQ-019 A digit captured twice before the frame completes SHALL overwrite its nibble; the seen-mask is unaffected.
REQ-020 Capture latency SHALL be STABLE_CYCLES+1 edges from an input change to hex_out/digit_valid update.
REQ-021 Error pulses and a frame_valid pulse MAY coincide; each SHALL be asserted for exactly one cycle.

Reset
REQ-022 While reset=0: hex_out=0, digit_valid=0, frame_valid=0, seg_error=0, anode_error=0, seen-mask=0, stability counter=0, input registers=all-ones (blank).
REQ-023 Reset asserted mid-capture or mid-frame SHALL discard all partial state immediately, without waiting for a clock edge.
REQ-024 After release, the first capture SHALL require a full STABLE_CYCLES stable run.

Verification
REQ-025 STABLE_CYCLES=4, anodes=FE, segments=30 held 10 cycles -> hex_out[3:0]=3 and digit_valid=01 at edge 5; exactly one capture.
REQ-026 Scan digits 0..7 with glyphs 1,2,3,4,5,6,7,8, 6 cycles each -> hex_out=32'h87654321, digit_valid=FF, one frame_valid pulse after digit 7, seen-mask back to 0.
REQ-027 anodes=FB, segments=7F (blank glyph) held 6 cycles -> seg_error pulses once, digit_valid[2]=0, nibble 2 unchanged.
REQ-028 anodes=FC held 6 cycles -> anode_error pulses once; hex_out and digit_valid unchanged.
REQ-029 Alternate segments every 2 cycles for 20 cycles with STABLE_CYCLES=4 -> no capture, no pulses.
REQ-030 Assert reset after 5 digits of a frame, release, then scan all 8 digits -> all outputs 0 during reset; exactly one frame_valid after digit 7 of the new scan.
